// File: rtl/core_if_ifu_pkg.sv
// Shared widths, reset PC, fetch-queue defaults and the queue entry type.
package core_if_ifu_pkg;

    localparam int CORE_PC_WIDTH   = 32;
    localparam int CORE_INST_WIDTH = 32;
    localparam int CORE_IFQ_DEPTH  = 2;

    localparam logic [CORE_PC_WIDTH-1:0]   CORE_RESET_PC = 32'h8000_0000;
    localparam logic [CORE_INST_WIDTH-1:0] CORE_INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [CORE_PC_WIDTH-1:0]   pc;
        logic [CORE_INST_WIDTH-1:0] inst;
        logic                       err;
        logic                       filled;
    } ifq_entry_t;

    // Force a fetch address onto a word boundary.
    function automatic logic [CORE_PC_WIDTH-1:0] align_pc(input logic [CORE_PC_WIDTH-1:0] pc);
        return {pc[CORE_PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/core_if_fetchq.sv
// Circular fetch queue: entries are allocated at request time and filled
// in order by responses, so the response path never needs to stall.
module core_if_fetchq
    import core_if_ifu_pkg::*;
#(
    parameter  int DEPTH = CORE_IFQ_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       alloc_i,
    input  logic [CORE_PC_WIDTH-1:0]   alloc_pc_i,
    input  logic                       fill_i,
    input  logic [CORE_INST_WIDTH-1:0] fill_inst_i,
    input  logic                       fill_err_i,
    input  logic                       pop_i,
    output ifq_entry_t                 head_o,
    output logic [CW-1:0]              count_o,
    output logic [CW-1:0]              unfilled_o
);

    ifq_entry_t      ent_q [DEPTH];
    logic [PW-1:0]   alloc_ptr_q;
    logic [PW-1:0]   fill_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   unfilled_q;

    // Storage, pointers and occupancy; a flush frees every entry at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].filled <= 1'b0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
        end else begin
            // Alloc, fill and pop always target distinct entries.
            if (alloc_i) begin
                ent_q[alloc_ptr_q] <= '{pc: alloc_pc_i, inst: '0, err: 1'b0, filled: 1'b0};
                alloc_ptr_q        <= alloc_ptr_q + 1'b1;
            end
            if (fill_i) begin
                ent_q[fill_ptr_q].inst   <= fill_err_i ? CORE_INST_NOP : fill_inst_i;
                ent_q[fill_ptr_q].err    <= fill_err_i;
                ent_q[fill_ptr_q].filled <= 1'b1;
                fill_ptr_q               <= fill_ptr_q + 1'b1;
            end
            if (pop_i) begin
                ent_q[rd_ptr_q].filled <= 1'b0;
                rd_ptr_q               <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_q + CW'(alloc_i) - CW'(pop_i);
            unfilled_q <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
        end
    end

    assign head_o     = ent_q[rd_ptr_q];
    assign count_o    = count_q;
    assign unfilled_o = unfilled_q;

endmodule

// File: rtl/core_if_ifu.sv
// Instruction fetch unit: sequential PC generation, request gating against
// queue space plus in-flight wrong-path responses, and redirect handling.
module core_if_ifu
    import core_if_ifu_pkg::*;
#(
    parameter logic [CORE_PC_WIDTH-1:0] RESET_PC  = CORE_RESET_PC,
    parameter int                       IFQ_DEPTH = CORE_IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_redirect_valid,
    input  logic [CORE_PC_WIDTH-1:0]   i_redirect_pc,
    output logic                       o_ifetch_req_valid,
    input  logic                       i_ifetch_req_ready,
    output logic [CORE_PC_WIDTH-1:0]   o_ifetch_req_addr,
    input  logic                       i_ifetch_rsp_valid,
    output logic                       o_ifetch_rsp_ready,
    input  logic [CORE_INST_WIDTH-1:0] i_ifetch_rsp_inst,
    input  logic                       i_ifetch_rsp_err,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [CORE_PC_WIDTH-1:0]   o_pc,
    output logic [CORE_INST_WIDTH-1:0] o_inst,
    output logic                       o_fetch_err
);

    localparam int CW = $clog2(IFQ_DEPTH) + 1;

    logic [CORE_PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]            drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]            count;
    logic [CW-1:0]            unfilled;
    logic [CW:0]              inflight;
    ifq_entry_t               head;
    logic                     req_fire;
    logic                     rsp_drop;
    logic                     rsp_keep;
    logic                     fill;
    logic                     pop;

    // Wrong-path responses still occupy memory slots, so they count against space.
    assign inflight           = {1'b0, count} + {1'b0, drop_cnt_q};
    assign o_ifetch_req_valid = rst_n & ~i_redirect_valid & (inflight < (CW+1)'(IFQ_DEPTH));
    assign o_ifetch_req_addr  = fetch_pc_q;
    assign o_ifetch_rsp_ready = 1'b1;
    assign req_fire           = o_ifetch_req_valid & i_ifetch_req_ready;

    assign rsp_drop = i_ifetch_rsp_valid & (drop_cnt_q != '0);
    assign rsp_keep = i_ifetch_rsp_valid & (drop_cnt_q == '0);
    assign fill     = rsp_keep & ~i_redirect_valid;

    assign valid_out   = rst_n & head.filled & ~i_redirect_valid;
    assign pop         = valid_out & ready_out;
    assign o_pc        = head.pc;
    assign o_inst      = head.inst;
    assign o_fetch_err = head.err;

    core_if_fetchq #(
        .DEPTH (IFQ_DEPTH)
    ) u_fetchq (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (i_redirect_valid),
        .alloc_i     (req_fire),
        .alloc_pc_i  (fetch_pc_q),
        .fill_i      (fill),
        .fill_inst_i (i_ifetch_rsp_inst),
        .fill_err_i  (i_ifetch_rsp_err),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .unfilled_o  (unfilled)
    );

    // Next fetch PC and drop count; a redirect turns all unfilled entries into drops.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (i_redirect_valid) begin
            fetch_pc_d = align_pc(i_redirect_pc);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + CORE_PC_WIDTH'(4);
        end
        drop_cnt_d = drop_cnt_q + (i_redirect_valid ? unfilled : '0)
                     - CW'(rsp_drop | (i_redirect_valid & rsp_keep));
    end

    // Fetch PC and drop counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
